regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised general-register file for the PA-RISC datapath: two asynchronous read ports, one synchronous write port, GR0 hardwired to zero.
- Adds a per-register pending-write scoreboard so the ID stage can detect RAW hazards on in-flight producers.
- Scoreboard is set at issue, cleared at writeback, and flushed on branch squash.
- Replaces per-register 32-bit register instances with a single width- and depth-generic block.

Parameters:
- WIDTH, 32, data width of each register in bits.
- NUM_REGS, 32, number of registers; power of two, at least 2.
- BYPASS, 1; 1 forwards same-cycle write data to read ports, 0 returns the stored value only.
- Derived localparam AW = $clog2(NUM_REGS), address width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clr  in  1  reset, asynchronous, active-high; clears all registers and the scoreboard.
- ra_a  in  AW  read address, port A.
- ra_b  in  AW  read address, port B.
- rd_a  out  WIDTH  read data, port A.
- rd_b  out  WIDTH  read data, port B.
- busy_a  out  1  register at ra_a has a pending write.
- busy_b  out  1  register at ra_b has a pending write.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  WIDTH  writeback data.
- issue_en  in  1  instruction with destination issuing this cycle.
- issue_rd  in  AW  destination of issuing instruction.
- flush  in  1  squash all in-flight producers.
- pending_cnt  out  AW+1  number of registers currently pending.

Behaviour:
- Reset: Clr high asynchronously forces all registers to 0 and all pending bits to 0. While Clr is high, rd_a, rd_b, busy_a, busy_b and pending_cnt are all 0, and clock edges are ignored. Clr asserted mid-operation discards any in-progress write or issue.
- Write: at posedge Clk, if we=1 and wa!=0, reg[wa] takes wd. Writes to wa=0 are silently dropped. Latency is 1 cycle to storage.
- Read: combinational, 0-cycle latency.
  - ra=0 returns 0.
  - If BYPASS=1, we=1, wa=ra and ra!=0, the port returns wd.
  - Otherwise the port returns reg[ra].
  - Ports A and B are independent; the same address on both ports is legal.
- Scoreboard, one pending bit per register; bit 0 is constant 0. At each posedge, evaluated in this priority order:
  1. flush=1: all bits cleared. issue_en that cycle is ignored; the we data write still occurs.
  2. Otherwise, if we=1 and wa!=0: pending[wa] is cleared.
  3. Then, if issue_en=1 and issue_rd!=0: pending[issue_rd] is set. Set wins over a same-register clear in the same cycle, because the new producer supersedes the retiring one.
- Issuing to an already-pending register leaves it pending. No count is kept, since only the latest producer matters.
- Busy:
  - busy_x = pending[ra_x], except 0 when ra_x=0.
  - If BYPASS=1, busy_x is also 0 when we=1 and wa=ra_x, because the data is forwarded this cycle.
  - busy is combinational from current state and inputs.
- pending_cnt: combinational population count of the pending bits, range 0..NUM_REGS-1.
- No X propagation: all addresses are in range by construction, since NUM_REGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - the default WIDTH and NUM_REGS constants;
  - the GR0 index constant (0);
  - a function for the AW+1 wide popcount.
- Sub-module register_n holds one storage cell: parameter WIDTH, ports Clk, Clr (async active-high), LE, D, Q.
  - The file instantiates NUM_REGS-1 copies in a generate loop, with LE = we & (wa==i).
  - GR0 is a constant, not an instance.
- Scoreboard, read muxes and bypass logic live in the top module.

Test Plan:
- Clr pulse mid-cycle after writing GR5=DEADBEEF → rd_a(ra_a=5) reads 00000000 immediately, before the next edge; busy_a=0; pending_cnt=0.
- we=1, wa=0, wd=FFFFFFFF; then read ra_a=0 → rd_a=00000000; pending_cnt unchanged.
- BYPASS=1: cycle N we=1, wa=7, wd=12345678 with ra_a=7 and ra_b=7 → both ports read 12345678 in cycle N, busy_a=busy_b=0. Repeat with BYPASS=0 → cycle N returns the old value 00000000, cycle N+1 returns 12345678.
- issue_en with issue_rd=3, then issue_rd=9 → pending_cnt=2, busy_a(ra_a=3)=1. Then we with wa=3 → pending_cnt=1, busy_a=0.
- Same edge: we=1, wa=4 and issue_en=1, issue_rd=4 with GR4 pending → GR4 still pending after the edge, and reg[4]=wd.
- GR2, GR6, GR10 pending; assert flush together with issue_en, issue_rd=11 → pending_cnt=0 after the edge, GR11 not pending, and a simultaneous we write still lands in storage.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the general-register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int GR0          = 0;
  localparam int MAX_REGS     = 1024;

  // Callers zero-extend their pending vector to MAX_REGS bits before counting.
  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_register_n.sv
// One general-register storage cell with load enable and asynchronous clear.
module register_n #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             LE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      Q <= '0;
    end else if (LE) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// General-register file (2 async reads, 1 sync write, GR0 = 0) with a per-register
// pending-write scoreboard for RAW hazard detection in ID.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [AW-1:0]    ra_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             flush,
  output logic [AW:0]      pending_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(GR0);

  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [MAX_REGS-1:0] pending_ext;
  logic                wr_valid;
  logic                fwd_a;
  logic                fwd_b;

  assign q[0]     = '0;
  assign wr_valid = we && (wa != ZERO_ADDR);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register_n #(.WIDTH(WIDTH)) u_reg (
      .Clk (Clk),
      .Clr (Clr),
      .LE  (we && (wa == AW'(i))),
      .D   (wd),
      .Q   (q[i])
    );
  end

  // A new producer supersedes a retiring one on the same register, so set follows clear.
  always_comb begin
    pending_nxt = pending;
    if (!flush) begin
      if (wr_valid) begin
        pending_nxt[wa] = 1'b0;
      end
      if (issue_en && (issue_rd != ZERO_ADDR)) begin
        pending_nxt[issue_rd] = 1'b1;
      end
    end else begin
      pending_nxt = '0;
    end
    pending_nxt[GR0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign fwd_a = (BYPASS != 0) && wr_valid && (wa == ra_a);
  assign fwd_b = (BYPASS != 0) && wr_valid && (wa == ra_b);

  // Outputs are forced low during Clr so a forwarded wd cannot leak out.
  always_comb begin
    rd_a   = '0;
    busy_a = 1'b0;
    if (!Clr && (ra_a != ZERO_ADDR)) begin
      rd_a   = fwd_a ? wd : q[ra_a];
      busy_a = fwd_a ? 1'b0 : pending[ra_a];
    end
  end

  always_comb begin
    rd_b   = '0;
    busy_b = 1'b0;
    if (!Clr && (ra_b != ZERO_ADDR)) begin
      rd_b   = fwd_b ? wd : q[ra_b];
      busy_b = fwd_b ? 1'b0 : pending[ra_b];
    end
  end

  always_comb begin
    pending_ext                = '0;
    pending_ext[NUM_REGS-1:0]  = pending;
  end

  assign pending_cnt = Clr ? '0 : (AW+1)'(popcount(pending_ext));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: BYPASS=1 and BYPASS=0 instances share stimulus
// and are checked every cycle against a behavioural register/pending model.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra_a = '0, ra_b = '0, wa = '0, issue_rd = '0;
  logic [W-1:0]  wd = '0;
  logic          we = 1'b0, issue_en = 1'b0, flush = 1'b0;

  logic [W-1:0]  rd_a1, rd_b1, rd_a0, rd_b0;
  logic          busy_a1, busy_b1, busy_a0, busy_b0;
  logic [AW:0]   cnt1, cnt0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(W), .NUM_REGS(N), .BYPASS(1)) u_byp (
    .Clk(clk), .Clr(rst), .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a1), .rd_b(rd_b1),
    .busy_a(busy_a1), .busy_b(busy_b1), .we(we), .wa(wa), .wd(wd),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .pending_cnt(cnt1)
  );

  regfile_scoreboard #(.WIDTH(W), .NUM_REGS(N), .BYPASS(0)) u_nob (
    .Clk(clk), .Clr(rst), .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a0), .rd_b(rd_b0),
    .busy_a(busy_a0), .busy_b(busy_b0), .we(we), .wa(wa), .wd(wd),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .pending_cnt(cnt0)
  );

  // Behavioural model: plain arrays of register values and pending flags.
  logic [W-1:0] m_reg  [N];
  bit           m_pend [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) m_reg[wa] = wd;
      if (flush) begin
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      end else begin
        if (we && wa != 0) m_pend[wa] = 1'b0;
        if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp);
    if (rst || ra == 0) return '0;
    if (byp && we && wa == ra) return wd;
    return m_reg[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra, input bit byp);
    if (rst || ra == 0) return 1'b0;
    if (byp && we && wa == ra) return 1'b0;
    return m_pend[ra];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    if (rst) return 0;
    for (int i = 0; i < N; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("model rd_a byp",   64'(rd_a1),   64'(exp_rd(ra_a, 1'b1)));
    chk("model rd_b byp",   64'(rd_b1),   64'(exp_rd(ra_b, 1'b1)));
    chk("model busy_a byp", 64'(busy_a1), 64'(exp_busy(ra_a, 1'b1)));
    chk("model busy_b byp", 64'(busy_b1), 64'(exp_busy(ra_b, 1'b1)));
    chk("model cnt byp",    64'(cnt1),    64'(exp_cnt()));
    chk("model rd_a nob",   64'(rd_a0),   64'(exp_rd(ra_a, 1'b0)));
    chk("model rd_b nob",   64'(rd_b0),   64'(exp_rd(ra_b, 1'b0)));
    chk("model busy_a nob", 64'(busy_a0), 64'(exp_busy(ra_a, 1'b0)));
    chk("model busy_b nob", 64'(busy_b0), 64'(exp_busy(ra_b, 1'b0)));
    chk("model cnt nob",    64'(cnt0),    64'(exp_cnt()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    tick(); tick();
    #2;
    chk("reset rd_a", 64'(rd_a1), 64'h0);
    chk("reset cnt",  64'(cnt1),  64'h0);
    rst = 1'b0;

    // Write GR5 and mark it pending, then Clr between edges.
    tick();
    we = 1'b1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    idle(); issue_en = 1'b1; issue_rd = 5; ra_a = 5;
    tick();
    idle();
    #2;
    chk("gr5 stored",  64'(rd_a1),   64'hDEADBEEF);
    chk("gr5 busy",    64'(busy_a1), 64'h1);
    chk("gr5 cnt",     64'(cnt1),    64'h1);
    rst = 1'b1;
    #1;
    chk("clr rd_a",    64'(rd_a1),   64'h0);
    chk("clr busy_a",  64'(busy_a1), 64'h0);
    chk("clr cnt",     64'(cnt1),    64'h0);
    tick();
    rst = 1'b0;
    tick();
    #2;
    chk("post clr rd_a", 64'(rd_a0), 64'h0);

    // Writes to GR0 are dropped.
    tick();
    we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; ra_a = 0;
    #2;
    chk("gr0 same cycle", 64'(rd_a1), 64'h0);
    tick();
    idle();
    #2;
    chk("gr0 read",  64'(rd_a1), 64'h0);
    chk("gr0 cnt",   64'(cnt1),  64'h0);

    // Bypass vs no bypass on GR7, with GR7 pending.
    issue_en = 1'b1; issue_rd = 7;
    tick();
    idle(); we = 1'b1; wa = 7; wd = 32'h12345678; ra_a = 7; ra_b = 7;
    #2;
    chk("byp rd_a",    64'(rd_a1),   64'h12345678);
    chk("byp rd_b",    64'(rd_b1),   64'h12345678);
    chk("byp busy_a",  64'(busy_a1), 64'h0);
    chk("byp busy_b",  64'(busy_b1), 64'h0);
    chk("nob rd_a N",  64'(rd_a0),   64'h0);
    chk("nob busy_a N",64'(busy_a0), 64'h1);
    tick();
    idle();
    #2;
    chk("nob rd_a N+1", 64'(rd_a0), 64'h12345678);
    chk("nob rd_b N+1", 64'(rd_b0), 64'h12345678);

    // Issue GR3, GR9; retire GR3.
    issue_en = 1'b1; issue_rd = 3;
    tick();
    issue_rd = 9;
    tick();
    idle(); ra_a = 3;
    #2;
    chk("two pend cnt",  64'(cnt1),    64'h2);
    chk("gr3 busy",      64'(busy_a1), 64'h1);
    we = 1'b1; wa = 3; wd = 32'h00000033;
    tick();
    idle();
    #2;
    chk("retire cnt",    64'(cnt1),    64'h1);
    chk("retire busy",   64'(busy_a1), 64'h0);

    // Set beats clear on the same register.
    issue_en = 1'b1; issue_rd = 4;
    tick();
    idle(); we = 1'b1; wa = 4; wd = 32'hA5A5A5A5; issue_en = 1'b1; issue_rd = 4;
    tick();
    idle(); ra_a = 4;
    #2;
    chk("gr4 still busy", 64'(busy_a1), 64'h1);
    chk("gr4 data",       64'(rd_a1),   64'hA5A5A5A5);
    chk("gr4 cnt",        64'(cnt1),    64'h2);

    // Flush with simultaneous issue and write.
    issue_en = 1'b1; issue_rd = 2;
    tick();
    issue_rd = 6;
    tick();
    issue_rd = 10;
    tick();
    idle();
    #2;
    chk("pre flush cnt", 64'(cnt1), 64'h5);
    flush = 1'b1; issue_en = 1'b1; issue_rd = 11; we = 1'b1; wa = 12; wd = 32'hCAFEF00D;
    tick();
    idle(); ra_a = 11; ra_b = 12;
    #2;
    chk("flush cnt",     64'(cnt1),    64'h0);
    chk("flush gr11",    64'(busy_a1), 64'h0);
    chk("flush write",   64'(rd_b1),   64'hCAFEF00D);

    // Mixed traffic, checked by the model only.
    for (int k = 0; k < 60; k++) begin
      we       = 1'($urandom_range(0, 1));
      wa       = AW'($urandom_range(0, N - 1));
      wd       = $urandom;
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = AW'($urandom_range(0, N - 1));
      flush    = ($urandom_range(0, 15) == 0);
      ra_a     = (k % 3 == 0) ? wa : AW'($urandom_range(0, N - 1));
      ra_b     = (k % 4 == 0) ? issue_rd : AW'($urandom_range(0, N - 1));
      tick();
    end
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
